// File: rtl/pause_dim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pause_dim_ctrl
// Purpose  : Merges user, external and OSD pause sources into a registered
//            pause_cpu. After DIM_SECS of continuous pause, it dims the video.
//            Define PAUSE_GREYSCALE_EN to dim to greyscale instead of halving.
// Revision : 1.0  initial release
// ============================================================================
module pause_dim_ctrl #(
  parameter int RW            = 2,
  parameter int GW            = 2,
  parameter int BW            = 2,
  parameter int NREQ          = 2,
  parameter int TICKS_PER_SEC = 11_000_000,
  parameter int DIM_SECS      = 10
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   user_button,
  input  logic [NREQ-1:0]        pause_request,
  input  logic                   OSD_STATUS,
  input  logic [1:0]             options,
  input  logic [RW+GW+BW-1:0]    rgb_in,
  output logic                   pause_cpu,
  output logic                   dim_active,
  output logic [NREQ+1:0]        pause_src,
  output logic [RW+GW+BW-1:0]    rgb_out
);

  localparam int c_PIX_W   = RW + GW + BW;
  localparam int c_PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]           c_DIM_SECS  = 8'(DIM_SECS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DIM   = 2'd2
  } dim_state_t;

  logic                 r_btn_meta;
  logic                 r_btn_sync;
  logic                 r_btn_prev;
  logic                 r_user_pause;
  logic                 w_btn_rise;
  logic [NREQ+1:0]      w_src_nxt;
  logic                 w_run;
  dim_state_t           r_state;
  dim_state_t           w_state_nxt;
  logic [c_PRESC_W-1:0] r_presc;
  logic [c_PRESC_W-1:0] w_presc_nxt;
  logic [7:0]           r_secs;
  logic [7:0]           w_secs_nxt;
  logic                 w_dim_nxt;
  logic [c_PIX_W-1:0]   w_dimmed;

  assign w_btn_rise = r_btn_sync & ~r_btn_prev;
  assign w_src_nxt  = {options[0] & OSD_STATUS, r_user_pause, pause_request};
  assign w_run      = pause_cpu & options[1];
  assign w_dim_nxt  = (w_state_nxt == ST_DIM);

  // Any cycle without an active, dim-enabled pause restarts the timer.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_secs_nxt  = r_secs;
    if (!w_run) begin
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
      w_secs_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_COUNT: begin
          if (r_presc == c_PRESC_MAX) begin
            w_presc_nxt = '0;
            w_secs_nxt  = r_secs + 8'd1;
            w_state_nxt = (w_secs_nxt == c_DIM_SECS) ? ST_DIM : ST_COUNT;
          end else begin
            w_presc_nxt = r_presc + 1'b1;
            w_state_nxt = ST_COUNT;
          end
        end
        ST_DIM: begin
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_presc_nxt = '0;
          w_secs_nxt  = '0;
        end
      endcase
    end
  end

`ifdef PAUSE_GREYSCALE_EN
  logic [7:0] w_r8;
  logic [7:0] w_g8;
  logic [7:0] w_b8;
  logic [7:0] w_yd;

  // Bit-replicate each channel to 8 bits, then take half of the weighted luma.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_r8[7-i] = rgb_in[c_PIX_W-1 - (i % RW)];
      w_g8[7-i] = rgb_in[GW+BW-1 - (i % GW)];
      w_b8[7-i] = rgb_in[BW-1 - (i % BW)];
    end
    w_yd = 8'(({2'b00, w_r8} + {1'b0, w_g8, 1'b0} + {2'b00, w_b8}) >> 3);
    w_dimmed = {w_yd[7 -: RW], w_yd[7 -: GW], w_yd[7 -: BW]};
  end
`else
  always_comb begin
    w_dimmed = {rgb_in[c_PIX_W-1 -: RW] >> 1,
                rgb_in[GW+BW-1 -: GW] >> 1,
                rgb_in[BW-1 -: BW] >> 1};
  end
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_btn_meta   <= 1'b0;
      r_btn_sync   <= 1'b0;
      r_btn_prev   <= 1'b0;
      r_user_pause <= 1'b0;
      pause_src    <= '0;
      pause_cpu    <= 1'b0;
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_secs       <= '0;
      dim_active   <= 1'b0;
      rgb_out      <= '0;
    end else begin
      r_btn_meta   <= user_button;
      r_btn_sync   <= r_btn_meta;
      r_btn_prev   <= r_btn_sync;
      r_user_pause <= r_user_pause ^ w_btn_rise;
      pause_src    <= w_src_nxt;
      pause_cpu    <= |w_src_nxt;
      r_state      <= w_state_nxt;
      r_presc      <= w_presc_nxt;
      r_secs       <= w_secs_nxt;
      // rgb_out and dim_active switch together on the same edge.
      dim_active   <= w_dim_nxt;
      rgb_out      <= w_dim_nxt ? w_dimmed : rgb_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pause_dim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pause_dim_ctrl
// Purpose  : Self-checking bench for pause_dim_ctrl (vector table, corner
//            sequences, randomized run against a behavioural model).
// Revision : 1.0  initial release
// ============================================================================
module tb_pause_dim_ctrl;

  localparam int RW        = 2;
  localparam int GW        = 2;
  localparam int BW        = 2;
  localparam int NREQ      = 2;
  localparam int TPS       = 4;
  localparam int DSECS     = 2;
  localparam int c_DIM_CYC = TPS * DSECS;
  localparam int c_NVEC    = 27;

  logic       clk_sys       = 1'b0;
  logic       reset         = 1'b1;
  logic       user_button   = 1'b0;
  logic       OSD_STATUS    = 1'b0;
  logic [1:0] pause_request = 2'b00;
  logic [1:0] options       = 2'b00;
  logic [5:0] rgb_in        = 6'b0;
  logic       pause_cpu;
  logic       dim_active;
  logic [3:0] pause_src;
  logic [5:0] rgb_out;

  pause_dim_ctrl #(
    .RW(RW), .GW(GW), .BW(BW), .NREQ(NREQ),
    .TICKS_PER_SEC(TPS), .DIM_SECS(DSECS)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
    .pause_request(pause_request), .OSD_STATUS(OSD_STATUS), .options(options),
    .rgb_in(rgb_in), .pause_cpu(pause_cpu), .dim_active(dim_active),
    .pause_src(pause_src), .rgb_out(rgb_out)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] req;
    logic       osd;
    logic [1:0] opt;
    logic [5:0] rgb;
    logic       e_p;
    logic [3:0] e_s;
    logic       e_d;
    logic [5:0] e_rgb;
  } vec_t;

  vec_t tbl [c_NVEC];

  function automatic vec_t mk(input logic [1:0] req, input logic osd, input logic [1:0] opt,
                              input logic [5:0] rgb, input logic p, input logic [3:0] s,
                              input logic d, input logic [5:0] er);
    vec_t v;
    v.req = req; v.osd = osd; v.opt = opt; v.rgb = rgb;
    v.e_p = p; v.e_s = s; v.e_d = d; v.e_rgb = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic p, input logic [3:0] s,
                         input logic d, input logic [5:0] rgb);
    chk({nm, ".pause"}, 32'(pause_cpu), 32'(p));
    chk({nm, ".src"},   32'(pause_src), 32'(s));
    chk({nm, ".dim"},   32'(dim_active), 32'(d));
    chk({nm, ".rgb"},   32'(rgb_out),   32'(rgb));
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Behavioural model: pause = OR of sources; dim after a streak of
  // c_DIM_CYC paused, dim-enabled cycles; button acts three edges late.
  logic       m_pause;
  logic       m_dim;
  logic       m_user;
  logic [3:0] m_src;
  logic [5:0] m_rgb;
  logic [4:0] m_bh;
  int         m_streak;

  function automatic logic [5:0] dimf(input logic [5:0] v);
    int r, g, b;
    r = int'(v[5:4]);
    g = int'(v[3:2]);
    b = int'(v[1:0]);
`ifdef PAUSE_GREYSCALE_EN
    begin
      int y;
      y = ((r * 85) + 2 * (g * 85) + (b * 85)) / 4;
      y = (y / 2) / 64;
      return {2'(y), 2'(y), 2'(y)};
    end
`else
    return {2'(r / 2), 2'(g / 2), 2'(b / 2)};
`endif
  endfunction

  task automatic model_reset();
    m_pause = 1'b0; m_dim = 1'b0; m_user = 1'b0;
    m_src = '0; m_rgb = '0; m_bh = '0; m_streak = 0;
  endtask

  task automatic model_edge();
    if (m_pause && options[1]) m_streak++;
    else m_streak = 0;
    m_bh = {m_bh[3:0], user_button};
    if (m_bh[3] && !m_bh[4]) m_user = ~m_user;
    m_src   = {options[0] & OSD_STATUS, m_user, pause_request};
    m_pause = |m_src;
    m_dim   = (m_streak >= c_DIM_CYC);
    m_rgb   = m_dim ? dimf(rgb_in) : rgb_in;
  endtask

  initial begin
    // Reset held with every input high
    reset = 1'b1; user_button = 1'b1; pause_request = 2'b11;
    OSD_STATUS = 1'b1; options = 2'b11; rgb_in = 6'b111111;
    step(); step(); step();
    chk_all("rst_hold", 1'b0, 4'b0, 1'b0, 6'b0);
    user_button = 1'b0; pause_request = 2'b00; OSD_STATUS = 1'b0;
    options = 2'b00; rgb_in = 6'b100110;
    reset = 1'b0;
    step();
    chk_all("rst_rel", 1'b0, 4'b0, 1'b0, 6'b100110);

    // Vector table
    tbl[0]  = mk(2'b00, 1'b0, 2'b00, 6'b101101, 1'b0, 4'b0000, 1'b0, 6'b101101);
    tbl[1]  = mk(2'b10, 1'b0, 2'b00, 6'b011011, 1'b1, 4'b0010, 1'b0, 6'b011011);
    tbl[2]  = mk(2'b00, 1'b0, 2'b00, 6'b000111, 1'b0, 4'b0000, 1'b0, 6'b000111);
    for (int i = 3; i <= 10; i++)
      tbl[i] = mk(2'b01, 1'b0, 2'b10, 6'b111111, 1'b1, 4'b0001, 1'b0, 6'b111111);
    tbl[11] = mk(2'b01, 1'b0, 2'b10, 6'b111111, 1'b1, 4'b0001, 1'b1, 6'b010101);
    tbl[12] = mk(2'b01, 1'b0, 2'b10, 6'b101010, 1'b1, 4'b0001, 1'b1, 6'b010101);
    tbl[13] = mk(2'b00, 1'b0, 2'b10, 6'b111111, 1'b0, 4'b0000, 1'b1, 6'b010101);
    tbl[14] = mk(2'b00, 1'b0, 2'b10, 6'b111111, 1'b0, 4'b0000, 1'b0, 6'b111111);
    tbl[15] = mk(2'b00, 1'b1, 2'b01, 6'b000000, 1'b1, 4'b1000, 1'b0, 6'b000000);
    tbl[16] = mk(2'b00, 1'b1, 2'b00, 6'b110011, 1'b0, 4'b0000, 1'b0, 6'b110011);
    for (int i = 17; i < c_NVEC; i++)
      tbl[i] = mk(2'b10, 1'b0, 2'b00, 6'b111111, 1'b1, 4'b0010, 1'b0, 6'b111111);

    do_reset();
    for (int i = 0; i < c_NVEC; i++) begin
      pause_request = tbl[i].req; OSD_STATUS = tbl[i].osd;
      options = tbl[i].opt; rgb_in = tbl[i].rgb;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_p, tbl[i].e_s, tbl[i].e_d, tbl[i].e_rgb);
    end

    // Button toggle: four-edge latency, persistence across request changes
    pause_request = 2'b00; OSD_STATUS = 1'b0; options = 2'b00; rgb_in = 6'b0;
    step(); step();
    chk("btn.idle", 32'(pause_cpu), 32'd0);
    user_button = 1'b1; step(); chk("btn.e1", 32'(pause_cpu), 32'd0);
    user_button = 1'b0; step(); chk("btn.e2", 32'(pause_cpu), 32'd0);
    step(); chk("btn.e3", 32'(pause_cpu), 32'd0);
    step(); chk("btn.e4", 32'(pause_cpu), 32'd1);
    chk("btn.e4src", 32'(pause_src), 32'h4);
    pause_request = 2'b01; step(); chk("btn.req", 32'(pause_src), 32'h5);
    pause_request = 2'b00; step(); chk("btn.drop", 32'(pause_cpu), 32'd1);
    chk("btn.dropsrc", 32'(pause_src), 32'h4);
    repeat (3) step();
    chk("btn.hold", 32'(pause_cpu), 32'd1);
    user_button = 1'b1; step();
    user_button = 1'b0; step(); step();
    chk("btn2.e3", 32'(pause_cpu), 32'd1);
    step(); chk("btn2.e4", 32'(pause_cpu), 32'd0);

    // Reset in the middle of a dim count, with a pending user toggle
    do_reset();
    options = 2'b10; pause_request = 2'b01;
    step(); chk("mid.start", 32'(pause_cpu), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      user_button = (k == 3);
      step();
      chk($sformatf("mid.c%0d", k), 32'(dim_active), 32'd0);
    end
    user_button = 1'b0;
    reset = 1'b1;
    #2;
    chk_all("mid.rst", 1'b0, 4'b0, 1'b0, 6'b0);
    step();
    reset = 1'b0; pause_request = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mid.idle%0d", k), 32'(pause_src), 32'd0);
    end
    pause_request = 2'b01;
    step(); chk("mid.restart", 32'(pause_cpu), 32'd1);
    for (int k = 1; k <= c_DIM_CYC; k++) begin
      step();
      chk($sformatf("mid.r%0d", k), 32'(dim_active), 32'(k == c_DIM_CYC));
    end

    // Randomized run against the model
    user_button = 1'b0; pause_request = 2'b00; OSD_STATUS = 1'b0; options = 2'b00;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) user_button = ~user_button;
      if ($urandom_range(0, 39) == 0) pause_request = 2'($urandom);
      if ($urandom_range(0, 19) == 0) OSD_STATUS = ~OSD_STATUS;
      if ($urandom_range(0, 59) == 0) options = 2'($urandom);
      rgb_in = 6'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1;
        step();
        model_reset();
        chk_all($sformatf("rnd%0d.rst", c), 1'b0, 4'b0, 1'b0, 6'b0);
        reset = 1'b0;
      end else begin
        step();
        model_edge();
        chk_all($sformatf("rnd%0d", c), m_pause, m_src, m_dim, m_rgb);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
